mcp3202_spi_responder: RTL and testbench

// Synthesizable stand-in for the MCP3202 ADC: the SPI responder that answers the SPI/AXI-stream ADC master.

---
 rtl/mcp3202_spi_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_mcp3202_spi_responder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mcp3202_spi_responder.sv
// mcp3202_spi_responder: MCP3202 ADC stand-in. Samples arrive on an AXI-stream
// port, the SPI master's start/config bits are decoded from MOSI and the
// selected 12-bit result is returned on MISO in MCP3202 frame format.
// Optional SCK-rate checker enabled by defining MCP3202_RESP_TCHK_EN.
module mcp3202_spi_responder #(
    parameter real FCLK     = 100e6,
    parameter real FSCK_MAX = 900e3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [15:0] s_axis_tdata,
    output logic        conv_done,
    output logic        cfg_sgl,
    output logic        cfg_odd,
    output logic        timing_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CFG, S_NULLB, S_MSB, S_LSB, S_DONE
    } state_t;

    // Negative pseudo-differential results read as zero.
    function automatic logic [11:0] clamp_nonneg(input logic signed [12:0] v);
        return (v < 0) ? 12'h000 : v[11:0];
    endfunction

    // Single-ended picks ch[odd]; pseudo-diff is ch[odd] - ch[~odd].
    function automatic logic [11:0] pick_result(input logic sgl, input logic odd,
                                                input logic [11:0] c0, input logic [11:0] c1);
        logic        [11:0] pos;
        logic        [11:0] neg;
        logic signed [12:0] diff;
        pos  = odd ? c1 : c0;
        neg  = odd ? c0 : c1;
        diff = $signed({1'b0, pos}) - $signed({1'b0, neg});
        return sgl ? pos : clamp_nonneg(diff);
    endfunction

    logic        cs_p0, cs_p1;
    logic        sck_p0, sck_p1, sck_p2;
    logic        mosi_p0, mosi_p1;
    logic        sck_rise, sck_fall;
    logic [11:0] ch0, ch1;
    logic        unused_tdata;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  cfg_q, cfg_d;     // {sgl, odd, msbf} of the frame in progress
    logic [11:0] res_q, res_d;
    logic        miso_d, oe_d, done_d, sgl_d, odd_d;

    assign unused_tdata = ^s_axis_tdata[15:13];

    // Two-flop synchronizers for the SPI pins plus one extra SCK stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            sck_p0  <= 1'b0;
            sck_p1  <= 1'b0;
            sck_p2  <= 1'b0;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            cs_p0   <= cs;
            cs_p1   <= cs_p0;
            sck_p0  <= sck;
            sck_p1  <= sck_p0;
            sck_p2  <= sck_p1;
            mosi_p0 <= mosi;
            mosi_p1 <= mosi_p0;
        end
    end

    assign sck_rise = sck_p1 & ~sck_p2;
    assign sck_fall = ~sck_p1 & sck_p2;

    // Sample registers: always ready, last write to a channel wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axis_tready <= 1'b0;
            ch0           <= 12'h000;
            ch1           <= 12'h000;
        end else begin
            s_axis_tready <= 1'b1;
            if (s_axis_tvalid && s_axis_tready) begin
                if (s_axis_tdata[12]) ch1 <= s_axis_tdata[11:0];
                else                  ch0 <= s_axis_tdata[11:0];
            end
        end
    end

    // FSM state and registered SPI outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            cfg_q     <= 3'b000;
            res_q     <= 12'h000;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            conv_done <= 1'b0;
            cfg_sgl   <= 1'b0;
            cfg_odd   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cfg_q     <= cfg_d;
            res_q     <= res_d;
            miso      <= miso_d;
            miso_oe   <= oe_d;
            conv_done <= done_d;
            cfg_sgl   <= sgl_d;
            cfg_odd   <= odd_d;
        end
    end

    // Frame decode: MOSI sampled on SCK rises, MISO shifted on SCK falls.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        res_d   = res_q;
        miso_d  = miso;
        oe_d    = miso_oe;
        done_d  = 1'b0;
        sgl_d   = cfg_sgl;
        odd_d   = cfg_odd;
        if (cs_p1) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_START;
                    oe_d    = 1'b1;
                    miso_d  = 1'b0;
                end
                S_START: begin
                    if (sck_rise && mosi_p1) begin
                        state_d = S_CFG;
                        cnt_d   = 4'd0;
                    end
                end
                S_CFG: begin
                    if (sck_rise) begin
                        cfg_d[2 - cnt_q[1:0]] = mosi_p1;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd2) begin
                            res_d   = pick_result(cfg_q[2], cfg_q[1], ch0, ch1);
                            state_d = S_NULLB;
                        end
                    end
                end
                S_NULLB: begin
                    if (sck_fall) begin
                        miso_d  = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = S_MSB;
                    end
                end
                S_MSB: begin
                    if (sck_fall) begin
                        miso_d = res_q[4'd11 - cnt_q];
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == 4'd11) begin
                            if (cfg_q[0]) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                sgl_d   = cfg_q[2];
                                odd_d   = cfg_q[1];
                            end else begin
                                state_d = S_LSB;
                                cnt_d   = 4'd1;
                            end
                        end
                    end
                end
                S_LSB: begin
                    if (sck_fall) begin
                        miso_d = res_q[cnt_q];
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == 4'd11) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                            sgl_d   = cfg_q[2];
                            odd_d   = cfg_q[1];
                        end
                    end
                end
                S_DONE: begin
                    if (sck_fall) miso_d = 1'b0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef MCP3202_RESP_TCHK_EN
    localparam int MIN_GAP = int'(FCLK / FSCK_MAX);

    logic [15:0] gap_cnt;
    logic        gap_armed;
    logic        terr;

    // Sticky flag when two SCK rises inside one frame are closer than MIN_GAP clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt   <= 16'd0;
            gap_armed <= 1'b0;
            terr      <= 1'b0;
        end else if (cs_p1) begin
            gap_cnt   <= 16'd0;
            gap_armed <= 1'b0;
        end else if (sck_rise) begin
            if (gap_armed && (gap_cnt < 16'(MIN_GAP))) terr <= 1'b1;
            gap_armed <= 1'b1;
            gap_cnt   <= 16'd1;
        end else if (gap_cnt != 16'hFFFF) begin
            gap_cnt <= gap_cnt + 16'd1;
        end
    end

    assign timing_err = terr;
`else
    logic unused_tchk;
    assign unused_tchk = (FCLK > 0.0) && (FSCK_MAX > 0.0);
    assign timing_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// Bench for mcp3202_spi_responder: table of frames plus hand-written abort,
// SCK-rate and async-reset sequences. Clock is 100 MHz.
module tb_mcp3202_spi_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic [15:0] s_axis_tdata = 16'h0000;
    logic        miso, miso_oe, s_axis_tready, conv_done, cfg_sgl, cfg_odd, timing_err;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    mcp3202_spi_responder dut (
        .clk(clk), .rst(rst), .cs(cs), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .conv_done(conv_done),
        .cfg_sgl(cfg_sgl), .cfg_odd(cfg_odd), .timing_err(timing_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (conv_done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic ch, input logic [11:0] val);
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {3'b101, ch, val};   // upper bits must be ignored
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 16'h0000;
    endtask

    // Master side of one frame; MISO is sampled just before each SCK rise.
    task automatic run_frame(input int lead, input logic sgl, input logic odd, input logic msbf,
                             input int nrise, input int half, input bit mid_wr,
                             output logic [63:0] cap, output logic oe_seen);
        logic b;
        cap = '0;
        oe_seen = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        for (int i = 0; i < nrise; i++) begin
            if (i < lead)           b = 1'b0;
            else if (i == lead)     b = 1'b1;
            else if (i == lead + 1) b = sgl;
            else if (i == lead + 2) b = odd;
            else if (i == lead + 3) b = msbf;
            else                    b = 1'b0;
            mosi = b;
            #half;
            if (i == 0) oe_seen = miso_oe;
            cap = {cap[62:0], miso};
            sck = 1'b1;
            #half;
            sck = 1'b0;
            if (mid_wr && i == lead + 6) begin
                axi_write(1'b0, 12'h000);
                axi_write(1'b1, 12'hFFF);
            end
        end
        #half;
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    typedef struct {
        int          lead;
        logic        sgl;
        logic        odd;
        logic        msbf;
        logic [11:0] c0;
        logic [11:0] c1;
        logic [11:0] res;
        logic [10:0] lsb;    // B1..B11 in transmit order (MSBF=0 only)
        bit          mid_wr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [63:0] cap;
        logic [63:0] exp;
        logic        oe_seen;
        int          d0;
        int          nrise;

        vecs[0] = '{0, 1'b1, 1'b0, 1'b1, 12'hA5C, 12'h000, 12'hA5C, 11'b0, 1'b1};
        vecs[1] = '{0, 1'b1, 1'b1, 1'b0, 12'hA5C, 12'h123, 12'h123, 11'b10001001000, 1'b0};
        vecs[2] = '{3, 1'b0, 1'b0, 1'b1, 12'h800, 12'h300, 12'h500, 11'b0, 1'b0};
        vecs[3] = '{0, 1'b0, 1'b1, 1'b1, 12'h800, 12'h300, 12'h000, 11'b0, 1'b0};
        vecs[4] = '{0, 1'b0, 1'b1, 1'b0, 12'h100, 12'hFFF, 12'hEFF, 11'b11111110111, 1'b0};

        // reset state while rst is held
        #20;
        check("rst_miso", 64'(miso), 64'd0);
        check("rst_oe", 64'(miso_oe), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_done", 64'(conv_done), 64'd0);
        check("rst_sgl", 64'(cfg_sgl), 64'd0);
        check("rst_odd", 64'(cfg_odd), 64'd0);
        check("rst_terr", 64'(timing_err), 64'd0);
        #5 rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("tready_up", 64'(s_axis_tready), 64'd1);

        // table of complete frames at 500 kHz
        for (int k = 0; k < 5; k++) begin
            axi_write(1'b0, ~vecs[k].c0);
            axi_write(1'b0, vecs[k].c0);
            axi_write(1'b1, vecs[k].c1);
            d0    = done_cnt;
            nrise = vecs[k].lead + 4 + 13 + (vecs[k].msbf ? 0 : 11);
            run_frame(vecs[k].lead, vecs[k].sgl, vecs[k].odd, vecs[k].msbf,
                      nrise, 1000, vecs[k].mid_wr, cap, oe_seen);
            exp = vecs[k].msbf ? 64'(vecs[k].res) : {41'b0, vecs[k].res, vecs[k].lsb};
            check($sformatf("stream%0d", k), cap, exp);
            check($sformatf("done%0d", k), 64'(done_cnt - d0), 64'd1);
            check($sformatf("sgl%0d", k), 64'(cfg_sgl), 64'(vecs[k].sgl));
            check($sformatf("odd%0d", k), 64'(cfg_odd), 64'(vecs[k].odd));
            check($sformatf("oe_on%0d", k), 64'(oe_seen), 64'd1);
            check($sformatf("oe_off%0d", k), 64'(miso_oe), 64'd0);
            check($sformatf("terr%0d", k), 64'(timing_err), 64'd0);
        end

        // aborted frame: cs rises after 5 bits
        d0 = done_cnt;
        run_frame(0, 1'b1, 1'b0, 1'b1, 5, 1000, 1'b0, cap, oe_seen);
        check("abort_oe_on", 64'(oe_seen), 64'd1);
        check("abort_oe_off", 64'(miso_oe), 64'd0);
        check("abort_done", 64'(done_cnt - d0), 64'd0);
        check("abort_sgl", 64'(cfg_sgl), 64'd0);
        check("abort_odd", 64'(cfg_odd), 64'd1);

        // roughly 2 MHz SCK (240 ns half period), ch1 still 12'hFFF
        d0 = done_cnt;
        run_frame(0, 1'b1, 1'b1, 1'b1, 17, 240, 1'b0, cap, oe_seen);
        check("fast_stream", cap, 64'h0FFF);
        check("fast_done", 64'(done_cnt - d0), 64'd1);
`ifdef MCP3202_RESP_TCHK_EN
        check("fast_terr", 64'(timing_err), 64'd1);
        run_frame(0, 1'b1, 1'b0, 1'b1, 17, 1000, 1'b0, cap, oe_seen);
        check("terr_held", 64'(timing_err), 64'd1);
`else
        check("fast_terr", 64'(timing_err), 64'd0);
`endif

        // async reset in the middle of the data phase
        @(negedge clk);
        cs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mosi = (i < 3) ? 1'b1 : 1'b0;
            #1000 sck = 1'b1;
            #1000 sck = 1'b0;
        end
        check("mid_oe", 64'(miso_oe), 64'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_oe", 64'(miso_oe), 64'd0);
        check("arst_sgl", 64'(cfg_sgl), 64'd0);
        check("arst_odd", 64'(cfg_odd), 64'd0);
        check("arst_tready", 64'(s_axis_tready), 64'd0);
        cs = 1'b1;
        mosi = 1'b0;
        #20 rst = 1'b0;
        repeat (5) @(negedge clk);

        // channel registers were cleared by the reset
        run_frame(0, 1'b1, 1'b1, 1'b1, 17, 1000, 1'b0, cap, oe_seen);
        check("post_rst_ch1", cap, 64'h0);
        check("post_rst_sgl", 64'(cfg_sgl), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
